// File: rtl/stepdown_gate_seq.sv
// Step-down switching-cycle sequencer: PWM request -> exclusive HS/LS drive enables with dead time, min on-time, OCP and hiccup.
// Outputs are flops decoded from next state, so every drive edge lands one clk after the deciding input sample.
module stepdown_gate_seq #(
    parameter int DTW        = 4,
    parameter int MIN_ON     = 3,
    parameter int OCP_MAX    = 4,
    parameter int HICCUP_CYC = 1024
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           CELV,
    input  logic           CELG,
    input  logic           SUB,
    input  logic           en,
    input  logic           pwm,
    input  logic           ocp,
    input  logic           zcd,
    input  logic           dcm_en,
    input  logic [DTW-1:0] dt_lh,
    input  logic [DTW-1:0] dt_hl,
    output logic           hs_on,
    output logic           ls_on,
    output logic           ocp_lat,
    output logic           hiccup,
    output logic [2:0]     state
);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_DLH   = 3'd1,
        S_HS_ON = 3'd2,
        S_DHL   = 3'd3,
        S_LS_ON = 3'd4,
        S_HICC  = 3'd5
    } state_e;

    localparam logic [15:0] HIC_LOAD = 16'(HICCUP_CYC - 1);

    state_e           state_q, state_d;
    logic [DTW-1:0]   dt_cnt_q, dt_cnt_d;
    logic [7:0]       on_cnt_q, on_cnt_d;
    logic [15:0]      hic_cnt_q, hic_cnt_d;
    logic [3:0]       ocp_cnt_q, ocp_cnt_d;
    logic             ocp_lat_q, ocp_lat_d;
    logic             hs_on_q, ls_on_q, hiccup_q;
    logic             dt_done;
    logic             on_reached;
    logic             ocp_trip;
    logic             ocp_set;
    logic             zc_off;
    logic             unused_supply;

    assign unused_supply = CELV ^ CELG ^ SUB;

    assign dt_done    = (dt_cnt_q == '0);
    assign on_reached = ({1'b0, on_cnt_q} + 9'd1) >= 9'(MIN_ON);
    assign ocp_trip   = ({1'b0, ocp_cnt_q} + 5'd1) == 5'(OCP_MAX);
    assign zc_off     = dcm_en & zcd;

    always_comb begin
        state_d   = state_q;
        dt_cnt_d  = dt_cnt_q;
        on_cnt_d  = on_cnt_q;
        hic_cnt_d = hic_cnt_q;
        ocp_cnt_d = ocp_cnt_q;
        ocp_lat_d = ocp_lat_q;
        ocp_set   = 1'b0;

        case (state_q)
            S_OFF: begin
                if (en && pwm && !ocp_lat_q) state_d = S_DLH;
            end
            S_DLH: begin
                if (!en)          state_d  = S_OFF;
                else if (dt_done) state_d  = S_HS_ON;
                else              dt_cnt_d = dt_cnt_q - DTW'(1);
            end
            S_HS_ON: begin
                if (on_cnt_q != 8'hFF) on_cnt_d = on_cnt_q + 8'd1;
                // OCP terminates regardless of minimum on-time
                if (!en) begin
                    state_d = S_DHL;
                end else if (ocp) begin
                    ocp_set   = 1'b1;
                    ocp_cnt_d = (ocp_cnt_q == 4'hF) ? ocp_cnt_q : ocp_cnt_q + 4'd1;
                    state_d   = ocp_trip ? S_HICC : S_DHL;
                end else if (!pwm && on_reached) begin
                    state_d   = S_DHL;
                    ocp_cnt_d = '0;
                end
            end
            S_DHL: begin
                if (dt_done) state_d  = (!en || zc_off) ? S_OFF : S_LS_ON;
                else         dt_cnt_d = dt_cnt_q - DTW'(1);
            end
            S_LS_ON: begin
                if (!en)                     state_d = S_OFF;
                else if (zc_off)             state_d = S_OFF;
                else if (pwm && !ocp_lat_q)  state_d = S_DLH;
            end
            S_HICC: begin
                if (!en) begin
                    state_d = S_OFF;
                end else if (hic_cnt_q == '0) begin
                    state_d   = S_OFF;
                    ocp_cnt_d = '0;
                    ocp_lat_d = 1'b0;
                end else begin
                    hic_cnt_d = hic_cnt_q - 16'd1;
                end
            end
            default: state_d = S_OFF;
        endcase

        // A low PWM phase re-arms the latch; a fresh termination in the same cycle wins.
        if (!pwm && state_q != S_HICC) ocp_lat_d = 1'b0;
        if (ocp_set)                   ocp_lat_d = 1'b1;
        if (!en)                       ocp_cnt_d = '0;

        if (state_d != state_q) begin
            case (state_d)
                S_DLH:   dt_cnt_d  = dt_lh;
                S_DHL:   dt_cnt_d  = dt_hl;
                S_HS_ON: on_cnt_d  = '0;
                S_HICC:  hic_cnt_d = HIC_LOAD;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_OFF;
            dt_cnt_q  <= '0;
            on_cnt_q  <= '0;
            hic_cnt_q <= '0;
            ocp_cnt_q <= '0;
            ocp_lat_q <= 1'b0;
            hs_on_q   <= 1'b0;
            ls_on_q   <= 1'b0;
            hiccup_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            dt_cnt_q  <= dt_cnt_d;
            on_cnt_q  <= on_cnt_d;
            hic_cnt_q <= hic_cnt_d;
            ocp_cnt_q <= ocp_cnt_d;
            ocp_lat_q <= ocp_lat_d;
            hs_on_q   <= (state_d == S_HS_ON);
            ls_on_q   <= (state_d == S_LS_ON);
            hiccup_q  <= (state_d == S_HICC);
        end
    end

    assign hs_on   = hs_on_q;
    assign ls_on   = ls_on_q;
    assign hiccup  = hiccup_q;
    assign ocp_lat = ocp_lat_q;
    assign state   = state_q;

endmodule

// File: tb/tb_stepdown_gate_seq.sv
// Bench for stepdown_gate_seq: directed scenarios plus randomized run against an elapsed-time reference model.
module tb_stepdown_gate_seq;

    localparam int DTW        = 4;
    localparam int MIN_ON     = 3;
    localparam int OCP_MAX    = 4;
    localparam int HICCUP_CYC = 1024;

    localparam int OFF = 0, DLH = 1, HSON = 2, DHL = 3, LSON = 4, HICC = 5;

    logic           clk = 1'b0;
    logic           rst, en, pwm, ocp, zcd, dcm_en;
    logic [DTW-1:0] dt_lh, dt_hl;
    logic           hs_on, ls_on, ocp_lat, hiccup;
    logic [2:0]     state;

    int checks = 0;
    int errors = 0;

    // Reference model: phase, cycles elapsed in phase, captured dead time, OCP run length, latch.
    int m_st  = 0;
    int m_el  = 0;
    int m_dt  = 0;
    int m_run = 0;
    bit m_lat = 1'b0;

    always #5 clk = ~clk;

    stepdown_gate_seq #(
        .DTW(DTW), .MIN_ON(MIN_ON), .OCP_MAX(OCP_MAX), .HICCUP_CYC(HICCUP_CYC)
    ) dut (
        .clk(clk), .rst(rst), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
        .en(en), .pwm(pwm), .ocp(ocp), .zcd(zcd), .dcm_en(dcm_en),
        .dt_lh(dt_lh), .dt_hl(dt_hl),
        .hs_on(hs_on), .ls_on(ls_on), .ocp_lat(ocp_lat), .hiccup(hiccup), .state(state)
    );

    task automatic model_tick();
        int  nx;
        bit  set_lat;
        nx      = m_st;
        set_lat = 1'b0;
        if (rst) begin
            m_st = OFF; m_el = 0; m_dt = 0; m_run = 0; m_lat = 1'b0;
            return;
        end
        case (m_st)
            OFF:  if (en && pwm && !m_lat) nx = DLH;
            DLH:  if (!en) nx = OFF; else if (m_el == m_dt) nx = HSON;
            HSON: begin
                if (!en) nx = DHL;
                else if (ocp) begin
                    set_lat = 1'b1;
                    nx = (m_run + 1 == OCP_MAX) ? HICC : DHL;
                    if (m_run < 15) m_run++;
                end else if (!pwm && (m_el + 1 >= MIN_ON)) begin
                    nx = DHL;
                    m_run = 0;
                end
            end
            DHL:  if (m_el == m_dt) nx = (!en || (dcm_en && zcd)) ? OFF : LSON;
            LSON: if (!en || (dcm_en && zcd)) nx = OFF; else if (pwm && !m_lat) nx = DLH;
            HICC: begin
                if (!en) nx = OFF;
                else if (m_el == HICCUP_CYC - 1) begin
                    nx = OFF; m_run = 0; m_lat = 1'b0;
                end
            end
            default: nx = OFF;
        endcase
        if (!pwm && m_st != HICC) m_lat = 1'b0;
        if (set_lat) m_lat = 1'b1;
        if (!en) m_run = 0;
        if (nx != m_st) begin
            m_el = 0;
            if (nx == DLH) m_dt = int'(dt_lh);
            else if (nx == DHL) m_dt = int'(dt_hl);
        end else begin
            m_el++;
        end
        m_st = nx;
    endtask

    task automatic step();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    function automatic logic [6:0] dut_vec();
        return {hs_on, ls_on, ocp_lat, hiccup, state};
    endfunction

    function automatic logic [6:0] mdl_vec();
        return {logic'(m_st == HSON), logic'(m_st == LSON), logic'(m_lat),
                logic'(m_st == HICC), 3'(m_st)};
    endfunction

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; pwm = 1'b0; ocp = 1'b0; zcd = 1'b0; dcm_en = 1'b0;
        dt_lh = '0; dt_hl = '0;
        step();
        rst = 1'b0;
    endtask

    // Stimulus only: one high-side pulse, optionally OCP-terminated on its first HS cycle.
    task automatic pulse(input bit with_ocp, output logic [2:0] end_state);
        pwm = 1'b1; ocp = 1'b0;
        for (int k = 0; k < 40 && state != 3'd2; k++) step();
        if (state != 3'd2) begin
            end_state = 3'b111;
            return;
        end
        if (with_ocp) begin
            ocp = 1'b1;
            step();
            end_state = state;
            ocp = 1'b0; pwm = 1'b0;
            if (state != 3'd5) step();
        end else begin
            pwm = 1'b0;
            for (int k = 0; k < 10 && state == 3'd2; k++) step();
            end_state = state;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; pwm = 1'b1; ocp = 1'b1; zcd = 1'b1; dcm_en = 1'b1;
        dt_lh = 4'd3; dt_hl = 4'd3;
        step(); step();
        checks++;
        if (dut_vec() !== 7'd0) begin
            errors++; $display("FAIL reset_outputs got=%b exp=%b", dut_vec(), 7'd0);
        end
        rst = 1'b0; en = 1'b0; pwm = 1'b0; ocp = 1'b0;
        step();
        checks++;
        if (dut_vec() !== mdl_vec()) begin
            errors++; $display("FAIL reset_idle got=%b exp=%b", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_normal();
        int first_hs, hs_cnt, dhl_cnt, first_st;
        first_hs = -1; hs_cnt = 0; dhl_cnt = 0; first_st = -1;
        do_reset();
        en = 1'b1; dt_lh = 4'd2; dt_hl = 4'd1; pwm = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            if (c == 14) pwm = 1'b0;
            step();
            if (c == 1) first_st = int'(state);
            if (hs_on && first_hs < 0) first_hs = c;
            if (hs_on) hs_cnt++;
            if (state == 3'd3) dhl_cnt++;
            checks++;
            if (hs_on && ls_on) begin
                errors++; $display("FAIL normal_overlap cyc=%0d hs=%b ls=%b", c, hs_on, ls_on);
            end
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL normal_model cyc=%0d got=%b exp=%b", c, dut_vec(), mdl_vec());
            end
        end
        checks++;
        if (first_st != DLH) begin errors++; $display("FAIL normal_dlh_entry got=%0d exp=%0d", first_st, DLH); end
        checks++;
        if (first_hs != 4) begin errors++; $display("FAIL normal_hs_start got=%0d exp=4", first_hs); end
        checks++;
        if (hs_cnt != 10) begin errors++; $display("FAIL normal_hs_len got=%0d exp=10", hs_cnt); end
        checks++;
        if (dhl_cnt != 2) begin errors++; $display("FAIL normal_dhl_len got=%0d exp=2", dhl_cnt); end
        checks++;
        if (ls_on !== 1'b1) begin errors++; $display("FAIL normal_ls_on got=%b exp=1", ls_on); end
    endtask

    task automatic test_min_on();
        int dlh_cnt, hs_cnt;
        dlh_cnt = 0; hs_cnt = 0;
        do_reset();
        en = 1'b1; dt_lh = 4'd0; dt_hl = 4'd0; pwm = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            pwm = 1'b0;
            if (state == 3'd1) dlh_cnt++;
            if (hs_on) hs_cnt++;
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL minon_model cyc=%0d got=%b exp=%b", c, dut_vec(), mdl_vec());
            end
        end
        checks++;
        if (dlh_cnt != 1) begin errors++; $display("FAIL minon_dlh_len got=%0d exp=1", dlh_cnt); end
        checks++;
        if (hs_cnt != MIN_ON) begin errors++; $display("FAIL minon_hs_len got=%0d exp=%0d", hs_cnt, MIN_ON); end
    endtask

    task automatic test_ocp_latch();
        int restarts;
        restarts = 0;
        do_reset();
        en = 1'b1; dt_lh = 4'd0; dt_hl = 4'd0; pwm = 1'b1;
        step(); step(); step();
        checks++;
        if (hs_on !== 1'b1) begin errors++; $display("FAIL ocp_pre_hs got=%b exp=1", hs_on); end
        ocp = 1'b1;
        step();
        ocp = 1'b0;
        checks++;
        if ({hs_on, ocp_lat, state} !== {1'b0, 1'b1, 3'd3}) begin
            errors++; $display("FAIL ocp_term got=%b exp=%b", {hs_on, ocp_lat, state}, {1'b0, 1'b1, 3'd3});
        end
        for (int c = 0; c < 8; c++) begin
            step();
            if (state == 3'd1 || hs_on) restarts++;
        end
        checks++;
        if (restarts != 0) begin errors++; $display("FAIL ocp_blocked restarts=%0d exp=0", restarts); end
        checks++;
        if (state !== 3'd4) begin errors++; $display("FAIL ocp_hold_ls got=%0d exp=4", state); end
        pwm = 1'b0;
        step();
        checks++;
        if (ocp_lat !== 1'b0) begin errors++; $display("FAIL ocp_lat_clear got=%b exp=0", ocp_lat); end
        pwm = 1'b1;
        step();
        checks++;
        if (state !== 3'd1) begin errors++; $display("FAIL ocp_restart got=%0d exp=1", state); end
        checks++;
        if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL ocp_model got=%b exp=%b", dut_vec(), mdl_vec()); end
    endtask

    task automatic test_hiccup();
        logic [2:0] es;
        int bad, hc;
        bad = 0; hc = 0;
        do_reset();
        en = 1'b1; dt_lh = 4'd0; dt_hl = 4'd0;
        for (int p = 0; p < 3; p++) begin pulse(1'b1, es); if (es != 3'd3) bad++; end
        pulse(1'b0, es); if (es != 3'd3) bad++;
        for (int p = 0; p < 3; p++) begin pulse(1'b1, es); if (es != 3'd3) bad++; end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL hic_count_reset bad_pulses=%0d exp=0", bad); end
        pulse(1'b1, es);
        checks++;
        if ({es, hiccup, hs_on} !== {3'd5, 1'b1, 1'b0}) begin
            errors++; $display("FAIL hic_entry got=%b exp=%b", {es, hiccup, hs_on}, {3'd5, 1'b1, 1'b0});
        end
        hc = hiccup ? 1 : 0;
        for (int k = 0; k < 1100 && hiccup; k++) begin
            step();
            if (hiccup) hc++;
        end
        checks++;
        if (hc != HICCUP_CYC) begin errors++; $display("FAIL hic_len got=%0d exp=%0d", hc, HICCUP_CYC); end
        checks++;
        if (dut_vec() !== 7'd0) begin errors++; $display("FAIL hic_exit got=%b exp=%b", dut_vec(), 7'd0); end
        pulse(1'b1, es);
        checks++;
        if (es !== 3'd3) begin errors++; $display("FAIL hic_cnt_cleared got=%0d exp=3", es); end
        checks++;
        if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL hic_model got=%b exp=%b", dut_vec(), mdl_vec()); end
    endtask

    task automatic test_dcm();
        bit saw_ls;
        saw_ls = 1'b0;
        do_reset();
        en = 1'b1; dcm_en = 1'b1; dt_lh = 4'd0; dt_hl = 4'd0; pwm = 1'b1;
        for (int k = 0; k < 20 && state != 3'd2; k++) step();
        pwm = 1'b0;
        for (int k = 0; k < 20 && state != 3'd4; k++) step();
        checks++;
        if (ls_on !== 1'b1) begin errors++; $display("FAIL dcm_ls_reached got=%b exp=1", ls_on); end
        zcd = 1'b1;
        step();
        checks++;
        if ({ls_on, state} !== 4'd0) begin errors++; $display("FAIL dcm_zcd_ls got=%b exp=%b", {ls_on, state}, 4'd0); end
        zcd = 1'b0; dt_hl = 4'd3; pwm = 1'b1;
        for (int k = 0; k < 20 && state != 3'd2; k++) step();
        pwm = 1'b0;
        for (int k = 0; k < 20 && state != 3'd3; k++) step();
        zcd = 1'b1;
        for (int k = 0; k < 10 && state == 3'd3; k++) begin
            step();
            if (ls_on) saw_ls = 1'b1;
        end
        checks++;
        if ({saw_ls, state} !== 4'd0) begin errors++; $display("FAIL dcm_skip_ls got=%b exp=%b", {saw_ls, state}, 4'd0); end
        zcd = 1'b0;
    endtask

    task automatic test_en_drop();
        bit saw_ls;
        saw_ls = 1'b0;
        do_reset();
        en = 1'b1; dt_lh = 4'd0; dt_hl = 4'd2; pwm = 1'b1;
        for (int k = 0; k < 20 && state != 3'd2; k++) step();
        en = 1'b0;
        step();
        checks++;
        if (state !== 3'd3) begin errors++; $display("FAIL en_hs_to_dhl got=%0d exp=3", state); end
        for (int k = 0; k < 10 && state == 3'd3; k++) begin
            step();
            if (ls_on) saw_ls = 1'b1;
        end
        checks++;
        if ({saw_ls, state} !== 4'd0) begin errors++; $display("FAIL en_dhl_to_off got=%b exp=%b", {saw_ls, state}, 4'd0); end
        en = 1'b1; dt_lh = 4'd5;
        step();
        checks++;
        if (state !== 3'd1) begin errors++; $display("FAIL en_dlh_entry got=%0d exp=1", state); end
        en = 1'b0;
        step();
        checks++;
        if (state !== 3'd0) begin errors++; $display("FAIL en_dlh_abort got=%0d exp=0", state); end
    endtask

    task automatic test_rst_mid();
        do_reset();
        en = 1'b1; dt_lh = 4'd1; pwm = 1'b1;
        for (int k = 0; k < 20 && state != 3'd2; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (dut_vec() !== 7'd0) begin errors++; $display("FAIL rst_mid_hs got=%b exp=%b", dut_vec(), 7'd0); end
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                pwm  = ~pwm;
                hold = $urandom_range(1, 12);
            end else begin
                hold--;
            end
            en    = ($urandom_range(0, 99) < 97);
            ocp   = ($urandom_range(0, 99) < 10);
            zcd   = ($urandom_range(0, 99) < 15);
            if ($urandom_range(0, 99) < 5) dcm_en = ~dcm_en;
            dt_lh = 4'($urandom_range(0, 15));
            dt_hl = 4'($urandom_range(0, 15));
            rst   = ($urandom_range(0, 999) < 3);
            step();
            checks++;
            if (hs_on && ls_on) begin
                errors++; $display("FAIL rand_overlap i=%0d hs=%b ls=%b", i, hs_on, ls_on);
            end
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL rand_model i=%0d got=%b exp=%b", i, dut_vec(), mdl_vec());
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; pwm = 1'b0; ocp = 1'b0; zcd = 1'b0; dcm_en = 1'b0;
        dt_lh = '0; dt_hl = '0;
        test_reset();
        test_normal();
        test_min_on();
        test_ocp_latch();
        test_hiccup();
        test_dcm();
        test_en_drop();
        test_rst_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/stepdown_gate_seq.md
Name: stepdown_gate_seq

Overview:
- Switching-cycle sequencer for the step-down power stage.
- Converts a PWM request into mutually exclusive high-side and low-side drive enables, which feed the stage's digital buffers.
- Enforces programmable dead time, minimum on-time and cycle-by-cycle overcurrent termination.
- Provides diode-emulation low-side turn-off and hiccup retry after repeated overcurrent events.

Parameters:
- DTW, 4: width of the dead-time inputs.
- MIN_ON, 3: minimum high-side on-time in clk cycles (1..255).
- OCP_MAX, 4: consecutive overcurrent-terminated pulses that trigger hiccup (1..15).
- HICCUP_CYC, 1024: hiccup off-time in clk cycles (1..65535).

Ports:
- clk, input, 1: core clock.
- rst, input, 1: synchronous reset, active-high.
- CELV, input, 1: supply, no logic function.
- CELG, input, 1: ground, no logic function.
- SUB, input, 1: substrate, no logic function.
- en, input, 1: converter enable.
- pwm, input, 1: PWM request (1 = high-side phase).
- ocp, input, 1: overcurrent comparator, synchronous to clk.
- zcd, input, 1: inductor zero-cross detect, synchronous to clk.
- dcm_en, input, 1: enables diode emulation.
- dt_lh, input, DTW: dead time before high-side on.
- dt_hl, input, DTW: dead time before low-side on.
- hs_on, output, 1: high-side drive enable.
- ls_on, output, 1: low-side drive enable.
- ocp_lat, output, 1: cycle-by-cycle overcurrent latch.
- hiccup, output, 1: hiccup in progress.
- state, output, 3: current state code.

Behaviour:
- Reset is synchronous, active-high on rst, and overrides everything. After reset:
  - state = OFF;
  - hs_on = ls_on = ocp_lat = hiccup = 0;
  - all counters = 0.
- All inputs are sampled at the rising edge of clk. Outputs are registered decodes of state:
  - hs_on = (state==HS_ON);
  - ls_on = (state==LS_ON);
  - hiccup = (state==HICC).
- hs_on and ls_on are never 1 in the same cycle. Every HS<->LS change passes through a DEAD state.
- State codes: OFF=0, DLH=1, HS_ON=2, DHL=3, LS_ON=4, HICC=5. Codes 6 and 7 go to OFF on the next cycle.
- Dead-time counter:
  - Entering DLH loads dt_lh; entering DHL loads dt_hl.
  - The counter decrements each cycle in the state.
  - The state exits on the cycle the counter is 0, so the state lasts dt+1 cycles (dt=0 gives 1 cycle).
  - dt inputs are captured only at state entry.
- OFF -> DLH when en & pwm & !ocp_lat.
- DLH:
  - en=0 -> OFF immediately.
  - Otherwise -> HS_ON at dead-time expiry, regardless of pwm.
- HS_ON:
  - on_cnt is cleared on entry and increments, saturating at 255.
  - Exits to DHL on any of:
    - en=0;
    - ocp=1 (overrides MIN_ON; sets ocp_lat and increments ocp_cnt, saturating at 15);
    - pwm=0 with on_cnt+1 >= MIN_ON (clears ocp_cnt).
  - If ocp=1 and ocp_cnt+1 == OCP_MAX, go to HICC instead of DHL; hs_on falls the same edge.
- DHL:
  - At expiry: en=0 -> OFF.
  - dcm_en & zcd -> OFF.
  - Otherwise -> LS_ON.
- LS_ON, priority en=0 > (dcm_en & zcd) > (pwm & !ocp_lat):
  - en=0 -> OFF.
  - dcm_en & zcd -> OFF (diode emulation).
  - pwm & !ocp_lat -> DLH.
  - Otherwise remain in LS_ON.
- HICC:
  - Loads hic_cnt = HICCUP_CYC-1 on entry, so both drives are off for HICCUP_CYC cycles.
  - At expiry -> OFF, clearing ocp_cnt and ocp_lat.
  - en=0 aborts the count -> OFF.
- ocp_lat:
  - Set on an OCP termination in HS_ON.
  - Cleared on any cycle with pwm=0, except while in HICC.
  - Blocks new high-side pulses until pwm returns low (one pulse per PWM period).
- en=0 also clears ocp_cnt.
- ocp outside HS_ON is ignored.

Test Plan:
- Reset, then en=1, pwm rises at cycle 0, dt_lh=2 -> DLH cycles 1-3, hs_on=1 from cycle 4; pwm falls after 10 HS cycles with dt_hl=1 -> DHL for 2 cycles, then ls_on=1. Check hs_on&ls_on never both 1.
- MIN_ON=3, pwm high for a single cycle -> hs_on high exactly 3 cycles; dt_lh=0 -> DLH exactly 1 cycle.
- ocp=1 on the 2nd HS_ON cycle -> hs_on falls next edge and ocp_lat=1. pwm held high -> no new DLH. pwm low 1 cycle -> ocp_lat clears, and the next pwm rise starts DLH.
- Four consecutive OCP-terminated pulses (OCP_MAX=4) -> 4th goes directly HS_ON->HICC, hiccup=1 for 1024 cycles, then OFF, with ocp_lat=0 and ocp_cnt=0. A normal pulse between OCP pulses resets the count.
- dcm_en=1, zcd asserted in LS_ON -> ls_on falls next edge, state=OFF. zcd high at DHL expiry -> LS_ON skipped.
- Deassert en in HS_ON -> DHL then OFF, no LS_ON. Deassert en in DLH -> OFF next edge. Assert rst mid-HS_ON -> all outputs 0 on next edge.
